// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the
// boot program loader. The master side sources the byte stream and
// observes the write port. The slave side is the loader itself.
interface imem_loader_if;
  // Byte stream: a byte moves on any cycle with rx_valid & rx_ready
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;

  // Instruction-memory write port, owned by the loader
  logic        im_we;
  logic [15:0] im_addr;
  logic [15:0] im_wdata;

  modport master (
    output rx_valid,
    output rx_byte,
    input  rx_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_byte,
    output rx_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Consumes a byte stream: a 16-bit word count N (high byte first), then
// N big-endian 16-bit words. It writes the words to instruction memory at
// addresses 0..N-1 and holds the CPU in reset until a load succeeds.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: when defined, a trailing
// checksum byte (8-bit sum of all preceding stream bytes) is consumed and
// compared, and a mismatch ends the load in the error state.
// ADDR_W is assumed to be at most 15 so a valid word count fits the
// (ADDR_W+1)-bit counter.
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          pc_reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned CntW = ADDR_W + 1;

  localparam logic [16:0]     MaxWordsW = 17'(MAX_WORDS);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StChk,
`endif
    StDone,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [7:0]        len_hi_q, len_hi_d;
  logic [CntW-1:0]   len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic              rx_ready;
  logic              xfer;
  logic              start_ok;
  logic [15:0]       len_full;
  logic              len_bad;
  logic [CntW-1:0]   cnt_inc;
  logic              last_word;

  assign xfer      = bus.rx_valid & rx_ready;
  // Start is only honoured from the resting states
  assign start_ok  = start & (state_q inside {StIdle, StDone, StErr});
  assign len_full  = {len_hi_q, bus.rx_byte};
  assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MaxWordsW);
  assign cnt_inc   = cnt_q + CntOne;
  assign last_word = (cnt_inc == len_q);

  // Next-state and datapath update for the stream parser
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLenHi;
          cnt_d   = '0;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_hi_d = bus.rx_byte;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          if (len_bad) begin
            state_d = StErr;
          end else begin
            len_d   = CntW'(len_full);
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (xfer) begin
          hi_d    = bus.rx_byte;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (xfer) begin
          // Word completes here; the write strobe appears next cycle
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = {hi_q, bus.rx_byte};
          cnt_d   = cnt_inc;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StDataHi;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (xfer) begin
          state_d = (bus.rx_byte == sum_q) ? StDone : StErr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running sum over every length and data byte; the checksum byte is excluded
  always_comb begin
    sum_d = sum_q;
    if (start_ok) begin
      sum_d = '0;
    end else if (xfer && (state_q != StChk)) begin
      sum_d = sum_q + bus.rx_byte;
    end
  end
`endif

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!pc_reset) begin
      state_q  <= StIdle;
      len_hi_q <= '0;
      len_q    <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Checksum accumulator register
  always_ff @(posedge clk) begin
    if (!pc_reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  // Status and handshake outputs decoded from the current state
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      StLenHi, StLenLo, StDataHi, StDataLo: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      StDone: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      StErr: begin
        err = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rx_ready = rx_ready;
  assign bus.im_we    = we_q;
  assign bus.im_addr  = 16'(addr_q);
  assign bus.im_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes expected writes and
// results when it hands over a byte; a negedge monitor pops and compares.
module tb_imem_loader;

  logic clk = 1'b0;
  logic pc_reset;
  logic start;
  logic cpu_hold, busy, done, err;

  imem_loader_if bus ();

  imem_loader #(
    .ADDR_W   (8),
    .MAX_WORDS(256)
  ) dut (
    .clk     (clk),
    .pc_reset(pc_reset),
    .start   (start),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  typedef struct packed {
    logic done;
    logic err;
    int   cyc;
  } res_t;

  wr_t  wq[$];
  res_t rq[$];

  // Stimulus table for the next load
  logic [7:0]  stim[0:15];
  int          nst;
  logic [15:0] expw[0:7];
  int          nw;
  int          exp_res;  // 0 none, 1 done, 2 err

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every write strobe and every done/err rise
  initial begin
    logic pd, pe;
    wr_t  w;
    res_t r;
    pd = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.im_we === 1'b1) begin
        if (wq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d, expected none",
                   bus.im_addr, bus.im_wdata, cyc);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(bus.im_addr), 32'(w.addr));
          chk("wr_data", 32'(bus.im_wdata), 32'(w.data));
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
      if ((done === 1'b1 && pd !== 1'b1) || (err === 1'b1 && pe !== 1'b1)) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: done %0b err %0b at cycle %0d, expected none",
                   done, err, cyc);
        end else begin
          r = rq.pop_front();
          chk("res_done", 32'(done), 32'(r.done));
          chk("res_err", 32'(err), 32'(r.err));
          chk("res_cpu_hold", 32'(cpu_hold), 32'(!r.done));
          chk("res_busy", 32'(busy), 32'd0);
          chk("res_rx_ready", 32'(bus.rx_ready), 32'd0);
          chk("res_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
      pd = done;
      pe = err;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_im_we"}, 32'(bus.im_we), 32'd0);
    chk({tag, "_im_addr"}, 32'(bus.im_addr), 32'd0);
    chk({tag, "_im_wdata"}, 32'(bus.im_wdata), 32'd0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Good stream 00 03 12 34 AB CD 0F 00; checksum byte appended when enabled
  task automatic set_good(input logic [7:0] chk_byte, input int res);
    stim[0] = 8'h00; stim[1] = 8'h03;
    stim[2] = 8'h12; stim[3] = 8'h34;
    stim[4] = 8'hAB; stim[5] = 8'hCD;
    stim[6] = 8'h0F; stim[7] = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim[8] = chk_byte;
    nst     = 9;
`else
    nst     = (chk_byte == 8'hD0) ? 8 : 8;
`endif
    expw[0] = 16'h1234;
    expw[1] = 16'hABCD;
    expw[2] = 16'h0F00;
    nw      = 3;
    exp_res = res;
  endtask

  task automatic set_len(input logic [7:0] hi, input logic [7:0] lo);
    stim[0] = hi;
    stim[1] = lo;
    nst     = 2;
    nw      = 0;
    exp_res = 2;
  endtask

  // Pulse start, then stream stim[0..nst-1] with 'gap' idle cycles per byte
  task automatic load(input int gap, input int mid_start);
    bit ok;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < nst; i++) begin
      bus.rx_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        if (i == mid_start && g == 0) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      bus.rx_valid = 1'b1;
      bus.rx_byte  = stim[i];
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (bus.rx_ready === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_ready_timeout: byte %0d not accepted, expected acceptance", i);
        bus.rx_valid = 1'b0;
        return;
      end
      // Transfer happens on the coming edge; its effects show in that cycle
      if (i >= 3 && (i % 2) == 1 && ((i - 3) / 2) < nw)
        wq.push_back('{addr: 16'((i - 3) / 2), data: expw[(i - 3) / 2], cyc: cyc + 1});
      if (i == nst - 1 && exp_res != 0)
        rq.push_back('{done: (exp_res == 1), err: (exp_res == 2), cyc: cyc + 1});
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 20 && (wq.size() != 0 || rq.size() != 0); t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_writes_pending"}, 32'(wq.size()), 32'd0);
    chk({tag, "_results_pending"}, 32'(rq.size()), 32'd0);
    wq.delete();
    rq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset has priority over start and an offered byte
    pc_reset     = 1'b0;
    start        = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    pc_reset = 1'b1;

    // Good load, back-to-back bytes
    set_good(8'hD0, 1);
    load(0, -1);
    drain("good");
    chk("good_done_level", 32'(done), 32'd1);
    chk("good_hold_level", 32'(cpu_hold), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum off by one: writes still land, load fails
    set_good(8'hD1, 2);
    load(0, -1);
    drain("badchk");
    chk("badchk_done_level", 32'(done), 32'd0);
`endif

    // Zero length
    set_len(8'h00, 8'h00);
    load(0, -1);
    drain("len0");

    // N = 257 exceeds MAX_WORDS
    set_len(8'h01, 8'h01);
    load(0, -1);
    drain("len257");
    chk("len257_err_level", 32'(err), 32'd1);

    // Three idle cycles per byte and a start pulse during the data phase
    set_good(8'hD0, 1);
    load(3, 4);
    drain("gaps");

    // Reset after the fifth byte: only word 0 gets written
    set_good(8'hD0, 0);
    nst = 5;
    nw  = 1;
    load(0, -1);
    pc_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midreset");
    @(posedge clk); #1;
    pc_reset = 1'b1;
    drain("midreset");

    // Reload after the reset starts again from address 0
    set_good(8'hD0, 1);
    load(0, -1);
    drain("reload");
    chk("reload_done_level", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the CPU's instruction memory before execution starts. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them to consecutive instruction-memory addresses from 0. It holds the CPU in reset until a load completes successfully. It sits beside the CPU and owns the instruction-memory write port.

## Interface
- ADDR_W, default 8: instruction-memory address bits in use; depth is 2^ADDR_W words.
- MAX_WORDS, default 256: largest accepted word count; must be ≤ 2^ADDR_W.
- clk  in  1  system clock; all state changes on the rising edge.
- pc_reset  in  1  reset; synchronous, active-low.
- start  in  1  begin-load request, sampled each cycle.
- rx_valid  in  1  rx_byte holds a valid byte.
- rx_byte  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte; a byte is transferred on any cycle with rx_valid & rx_ready.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  16  write address; bits above ADDR_W are 0.
- im_wdata  out  16  write data.
- cpu_hold  out  1  1 keeps the CPU in reset.
- busy  out  1  a load is in progress.
- done  out  1  last load succeeded.
- err  out  1  last load failed.

## Operation
- Stream format:
  - Two length bytes N, high byte first.
  - N words, each sent as 2 bytes, high byte first, so the opcode nibble arrives first.
  - One checksum byte, present only with the configuration macro defined.
- Checksum: 8-bit sum, modulo 256, of every byte from the length high byte through the last data low byte.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR.
- Transitions:
  - IDLE, DONE or ERR with start=1 → LEN_HI. The same edge clears done and err and sets busy and cpu_hold.
  - start is ignored in all other states.
  - LEN_HI → LEN_LO on a byte transfer.
  - LEN_LO → DATA_HI on a byte transfer.
  - LEN_LO → ERR instead if N==0 or N>MAX_WORDS. No writes are issued in that case.
  - DATA_HI → DATA_LO on a byte transfer.
  - DATA_LO → DATA_HI on a byte transfer while words remain.
  - DATA_LO → CHK on the byte transfer that completes word N.
  - CHK → DONE if the checksum byte equals the running sum; otherwise CHK → ERR.
- rx_ready is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK. It is 0 on the cycle a state is entered from IDLE/DONE/ERR.
- The word counter is ADDR_W+1 bits wide. im_addr increments after each write: 0, 1, …, N-1. It never wraps within a load.
- DONE: done=1, busy=0, cpu_hold=0. DONE is held until the next start.
- ERR: err=1, busy=0, cpu_hold=1. Words already written are not rolled back.

## Timing
- Reset values (pc_reset low at an edge): state IDLE, rx_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, busy=0, done=0, err=0.
- Reset mid-load: the loader returns to these values on the next edge. No further im_we pulses are issued and any partial word is discarded.
- Reset has priority over start.
- Write latency: im_we=1 on the cycle immediately after the DATA_LO byte transfer. im_addr and im_wdata are valid in that same cycle. im_we is 0 otherwise.
- Result latency: done or err rises on the cycle after the final byte transfer, which is the checksum byte (or the last DATA_LO byte without checksum). For a bad length, it rises on the cycle after the LEN_LO transfer.
- cpu_hold falls in the same cycle done rises.
- Throughput: one byte per cycle when rx_valid is held high. Gaps in rx_valid stall the FSM with no state change.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: the CHK state exists, the checksum byte is consumed and compared, and a mismatch leads to ERR.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - No running sum and no CHK state.
  - DATA_LO → DONE on the transfer completing word N.
  - The only error is a bad length.

## Test plan
- Reset: hold pc_reset=0 for 2 cycles with start=1 and rx_valid=1 → all outputs at their reset values; cpu_hold=1.
- Good load (macro on): start, then bytes 00 03 12 34 AB CD 0F 00 D0 streamed back-to-back → writes (0,0x1234), (1,0xABCD), (2,0x0F00), each one cycle after its low byte; done=1 and cpu_hold=0 one cycle after 0xD0.
- Bad checksum: same stream ending in D1 → three writes occur; err=1, done=0, cpu_hold=1.
- Bad length: start, then bytes 00 00 → err=1 one cycle after the second byte, no im_we, rx_ready=0. Repeat with 01 01 (N=257 > 256) → same result.
- Backpressure and gaps: good-load stream with rx_valid low for 3 cycles between every byte, plus a start pulse issued mid-load → identical writes and result; the mid-load start has no effect.
- Reset mid-load: pc_reset=0 after the 5th byte, then restart with the good-load stream → no write after reset; the reload writes from address 0 and ends with done=1.
